// File: rtl/plic_lite_core.sv
// Lightweight platform interrupt controller core: per-source gateways, per-target
// priority arbitration with threshold, and a single-port config/claim/complete bus.
module plic_lite_core #(
  parameter int SOURCES = 8,
  parameter int TARGETS = 2,
  parameter int PRIO_W  = 3
) (
  input  logic               h_clk,
  input  logic               h_rst,
  input  logic [SOURCES-1:0] src,
  output logic [TARGETS-1:0] irq,
  input  logic               cfg_we,
  input  logic               cfg_re,
  input  logic [11:0]        cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               cfg_rvalid
);

  localparam logic [1:0] GW_IDLE = 2'd0;
  localparam logic [1:0] GW_PEND = 2'd1;
  localparam logic [1:0] GW_CLMD = 2'd2;

  logic [PRIO_W-1:0]  prio_q [SOURCES];
  logic [PRIO_W-1:0]  prio_d [SOURCES];
  logic [SOURCES-1:0] en_q   [TARGETS];
  logic [SOURCES-1:0] en_d   [TARGETS];
  logic [PRIO_W-1:0]  thr_q  [TARGETS];
  logic [PRIO_W-1:0]  thr_d  [TARGETS];
  logic [1:0]         gw_q   [SOURCES];
  logic [1:0]         gw_d   [SOURCES];
  logic [TARGETS-1:0] irq_q, irq_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rvalid_q;

  logic [3:0]         region_s;
  logic [7:0]         idx_s;
  logic               tgt_ok_s;
  logic               claim_s;
  logic               cmpl_s;
  logic [4:0]         claim_id_s;
  logic [4:0]         winner_s [TARGETS];
  logic [PRIO_W-1:0]  best_p_s;
  logic [4:0]         best_id_s;
  logic               hit_s;
  logic [SOURCES-1:0] pend_s;
  logic               unused_s;

  assign region_s = cfg_addr[11:8];
  assign idx_s    = cfg_addr[7:0];
  assign tgt_ok_s = (idx_s < 8'(TARGETS));
  assign claim_s  = cfg_re && !cfg_we && (region_s == 4'h3) && tgt_ok_s;
  assign cmpl_s   = cfg_we && (region_s == 4'h3) && tgt_ok_s;
  assign unused_s = ^cfg_wdata;

  // Per-target arbitration: seeding the best priority with the threshold makes
  // the compare strict and keeps priority 0 out; strict '>' keeps the lowest ID on ties.
  always_comb begin
    best_p_s  = '0;
    best_id_s = 5'd0;
    hit_s     = 1'b0;
    for (int t = 0; t < TARGETS; t++) begin
      best_p_s  = thr_q[t];
      best_id_s = 5'd0;
      for (int i = 0; i < SOURCES; i++) begin
        hit_s     = (gw_q[i] == GW_PEND) && en_q[t][i] && (prio_q[i] > best_p_s);
        best_p_s  = hit_s ? prio_q[i] : best_p_s;
        best_id_s = hit_s ? 5'(i + 1) : best_id_s;
      end
      winner_s[t] = best_id_s;
    end
  end

  always_comb begin
    claim_id_s = 5'd0;
    pend_s     = '0;
    for (int t = 0; t < TARGETS; t++) begin
      claim_id_s = (idx_s == 8'(t)) ? winner_s[t] : claim_id_s;
    end
    for (int i = 0; i < SOURCES; i++) begin
      pend_s[i] = (gw_q[i] == GW_PEND);
    end
  end

  // Configuration writes and gateway next-state
  always_comb begin
    prio_d = prio_q;
    en_d   = en_q;
    thr_d  = thr_q;
    gw_d   = gw_q;
    for (int i = 0; i < SOURCES; i++) begin
      prio_d[i] = (cfg_we && region_s == 4'h0 && idx_s == 8'(i + 1)) ?
                  cfg_wdata[PRIO_W-1:0] : prio_q[i];
      case (gw_q[i])
        GW_IDLE: gw_d[i] = src[i] ? GW_PEND : GW_IDLE;
        GW_PEND: gw_d[i] = (claim_s && claim_id_s == 5'(i + 1)) ? GW_CLMD : GW_PEND;
        GW_CLMD: gw_d[i] = (cmpl_s && cfg_wdata[4:0] == 5'(i + 1)) ? GW_IDLE : GW_CLMD;
        default: gw_d[i] = GW_IDLE;
      endcase
    end
    for (int t = 0; t < TARGETS; t++) begin
      en_d[t]  = (cfg_we && region_s == 4'h1 && idx_s == 8'(t)) ?
                 cfg_wdata[SOURCES-1:0] : en_q[t];
      thr_d[t] = (cfg_we && region_s == 4'h2 && idx_s == 8'(t)) ?
                 cfg_wdata[PRIO_W-1:0] : thr_q[t];
      irq_d[t] = (winner_s[t] != 5'd0);
    end
  end

  // Read mux; a read colliding with a write returns 0
  always_comb begin
    rdata_d = 32'd0;
    if (cfg_re && !cfg_we) begin
      if (cfg_addr == 12'h400) begin
        rdata_d = 32'(pend_s);
      end else begin
        for (int i = 0; i < SOURCES; i++) begin
          rdata_d = (region_s == 4'h0 && idx_s == 8'(i + 1)) ? 32'(prio_q[i]) : rdata_d;
        end
        for (int t = 0; t < TARGETS; t++) begin
          rdata_d = (region_s == 4'h1 && idx_s == 8'(t)) ? 32'(en_q[t])  : rdata_d;
          rdata_d = (region_s == 4'h2 && idx_s == 8'(t)) ? 32'(thr_q[t]) : rdata_d;
        end
        rdata_d = claim_s ? 32'(claim_id_s) : rdata_d;
      end
    end else begin
      rdata_d = 32'd0;
    end
  end

  // State registers
  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) begin
      for (int i = 0; i < SOURCES; i++) begin
        prio_q[i] <= '0;
        gw_q[i]   <= GW_IDLE;
      end
      for (int t = 0; t < TARGETS; t++) begin
        en_q[t]  <= '0;
        thr_q[t] <= '0;
      end
      irq_q    <= '0;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
    end else begin
      prio_q   <= prio_d;
      gw_q     <= gw_d;
      en_q     <= en_d;
      thr_q    <= thr_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
      rvalid_q <= cfg_re;
    end
  end

  assign irq        = irq_q;
  assign cfg_rdata  = rdata_q;
  assign cfg_rvalid = rvalid_q;

endmodule

// File: tb/tb_plic_lite_core.sv
// Directed bench for plic_lite_core: reads are checked by a scoreboard monitor,
// irq levels are checked inline at fixed latencies.
module tb_plic_lite_core;

  logic        h_clk = 1'b0;
  logic        h_rst;
  logic [7:0]  src;
  logic [1:0]  irq;
  logic        cfg_we, cfg_re;
  logic [11:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        cfg_rvalid;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q [$];
  string       nm_q  [$];

  plic_lite_core #(.SOURCES(8), .TARGETS(2), .PRIO_W(3)) dut (
    .h_clk(h_clk), .h_rst(h_rst), .src(src), .irq(irq),
    .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid)
  );

  always #5 h_clk = ~h_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Read-response monitor
  always @(negedge h_clk) begin
    if (cfg_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rvalid: got rdata %0h expected no response", cfg_rdata);
      end else begin
        chk(nm_q.pop_front(), cfg_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge h_clk);
      #1;
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    cfg_addr  = a;
    cfg_wdata = d;
    cfg_we    = 1'b1;
    tick(1);
    cfg_we    = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    cfg_addr = a;
    cfg_re   = 1'b1;
    tick(1);
    cfg_re   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    h_rst = 1'b1; src = 8'h00; cfg_we = 1'b0; cfg_re = 1'b0;
    cfg_addr = 12'h000; cfg_wdata = 32'd0;
    #12;
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rvalid", 32'(cfg_rvalid), 32'd0);
    chk("rst_rdata", cfg_rdata, 32'd0);
    @(posedge h_clk); #1;
    h_rst = 1'b0;

    // Single source with latency and re-pend after complete
    wr(12'h003, 32'd2); wr(12'h100, 32'h04); wr(12'h200, 32'd0);
    src = 8'h04;
    tick(1); chk("t1_irq_lat1", 32'(irq), 32'd0);
    tick(1); chk("t1_irq_lat2", 32'(irq), 32'd1);
    rd(12'h300, 32'd3, "t1_claim");
    tick(1); chk("t1_irq_drop", 32'(irq), 32'd0);
    wr(12'h300, 32'd3);
    tick(1); chk("t1_repend_lat1", 32'(irq), 32'd0);
    tick(1); chk("t1_repend_lat2", 32'(irq), 32'd1);
    rd(12'h300, 32'd3, "t1_claim2");
    src = 8'h00;
    wr(12'h300, 32'd3);

    // Priority order and tie-break
    wr(12'h001, 32'd5); wr(12'h002, 32'd5); wr(12'h004, 32'd6); wr(12'h000, 32'd7);
    wr(12'h100, 32'h0B);
    src = 8'h0B;
    tick(2); chk("t2_irq", 32'(irq), 32'd1);
    rd(12'h300, 32'd4, "t2_claim_a");
    rd(12'h300, 32'd1, "t2_claim_b");
    rd(12'h300, 32'd2, "t2_claim_c");
    rd(12'h300, 32'd0, "t2_claim_empty");
    rd(12'h400, 32'd0, "t2_pending");
    rd(12'h004, 32'd6, "t2_prio4");
    rd(12'h000, 32'd0, "t2_prio0");
    rd(12'h100, 32'h0B, "t2_enable0");
    src = 8'h00;
    wr(12'h300, 32'd4); wr(12'h300, 32'd1); wr(12'h300, 32'd2);

    // Strict threshold
    wr(12'h005, 32'd3); wr(12'h101, 32'h10); wr(12'h201, 32'd3);
    src = 8'h10;
    tick(3); chk("t3_thr_equal", 32'(irq), 32'd0);
    wr(12'h201, 32'd2);
    tick(1); chk("t3_thr_below", 32'(irq), 32'd2);
    rd(12'h301, 32'd5, "t3_claim");
    src = 8'h00;
    wr(12'h300, 32'd5);

    // One source shared by two targets
    wr(12'h006, 32'd1); wr(12'h100, 32'h20); wr(12'h101, 32'h20); wr(12'h201, 32'd0);
    src = 8'h20;
    tick(2); chk("t4_irq_both", 32'(irq), 32'd3);
    rd(12'h301, 32'd6, "t4_claim_t1");
    rd(12'h300, 32'd0, "t4_claim_t0");
    chk("t4_irq_none", 32'(irq), 32'd0);
    src = 8'h00;
    wr(12'h300, 32'd6);

    // Complete of an idle source, then we+re collision, enable masking
    wr(12'h007, 32'd4); wr(12'h100, 32'h40);
    wr(12'h300, 32'd7);
    rd(12'h400, 32'd0, "t5_pending_after_bad_cmpl");
    src = 8'h40;
    tick(2); chk("t5_irq", 32'(irq), 32'd1);
    rd(12'h300, 32'd7, "t5_claim");
    src = 8'h00;
    exp_q.push_back(32'd0);
    nm_q.push_back("t5_we_re_rdata");
    cfg_addr = 12'h101; cfg_wdata = 32'h7F; cfg_we = 1'b1; cfg_re = 1'b1;
    tick(1);
    cfg_we = 1'b0; cfg_re = 1'b0;
    rd(12'h101, 32'h7F, "t5_we_re_write");
    wr(12'h100, 32'hFFFF_FFFF);
    rd(12'h100, 32'hFF, "t5_enable_mask");

    // Reset while source 2 is claimed and source 1 pending
    wr(12'h100, 32'h02);
    src = 8'h03;
    tick(2);
    rd(12'h300, 32'd2, "t6_claim");
    tick(1); chk("t6_irq_pre_rst", 32'(irq), 32'd2);
    rd(12'h400, 32'h01, "t6_pending_pre_rst");
    tick(1);
    #2 h_rst = 1'b1;
    #1;
    chk("t6_rst_irq", 32'(irq), 32'd0);
    chk("t6_rst_rvalid", 32'(cfg_rvalid), 32'd0);
    chk("t6_rst_rdata", cfg_rdata, 32'd0);
    src = 8'h00;
    @(posedge h_clk); #1;
    h_rst = 1'b0;
    rd(12'h400, 32'd0, "t6_pending_post_rst");
    rd(12'h002, 32'd0, "t6_prio_post_rst");
    rd(12'h300, 32'd0, "t6_claim_post_rst");
    tick(1); chk("t6_irq_post_rst", 32'(irq), 32'd0);

    tick(2);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/plic_lite_core.md
# plic_lite_core

Interrupt-controller core at the far end of the `ir_if` source/target interface: it samples the `src` level-interrupt vector, gates each source, arbitrates by priority per target and drives the `irq` vector back to the bench. Software-side access is a simple single-port register bus (`cfg_*`) used for priority, enable and threshold programming and for claim/complete. It is the DUT that the `ir_if` driver stimulates and the monitor observes.

## Interface
- `SOURCES`, default 8: number of interrupt sources, range 1..31. IDs run 1..SOURCES; ID 0 means "no interrupt".
- `TARGETS`, default 2: number of interrupt targets, range 1..16.
- `PRIO_W`, default 3: priority and threshold width in bits.
- `h_clk`, input, 1: sole clock, rising edge.
- `h_rst`, input, 1: reset, asynchronous and active-high.
- `src`, input, SOURCES: level interrupt requests; `src[i-1]` is source ID i.
- `irq`, output, TARGETS: per-target interrupt request, registered.
- `cfg_we`, input, 1: register write strobe.
- `cfg_re`, input, 1: register read strobe.
- `cfg_addr`, input, 12: word address.
- `cfg_wdata`, input, 32: write data.
- `cfg_rdata`, output, 32: read data, registered.
- `cfg_rvalid`, output, 1: pulses one cycle after every `cfg_re`.

## Operation
**Register map.** Unmapped reads return 0; unmapped writes are ignored.
- 0x000+i: priority of source i, RW, PRIO_W bits, upper bits truncated. Address 0x000 reads 0 and ignores writes.
- 0x100+t: enable word of target t, RW. Bit i-1 enables source i. Bits at SOURCES and above read 0.
- 0x200+t: threshold of target t, RW, PRIO_W bits.
- 0x300+t, read: claim for target t. Returns the winning ID (or 0), clears that source's pending bit and moves its gateway to CLAIMED. A claim that returns 0 has no side effect.
- 0x300+t, write: complete. If `cfg_wdata[4:0]` is a source in CLAIMED, that gateway returns to IDLE; otherwise the write is ignored. Completion is not checked against the target or the enable bits.
- 0x400: pending vector, read-only.

**Gateway, one per source.**
- IDLE: `src` high sets pending and moves to PENDING.
- PENDING: a claim clears pending and moves to CLAIMED.
- CLAIMED: `src` is ignored; a complete returns the gateway to IDLE.
- If `src` is still high in IDLE, the source re-pends on the next edge.

**Arbitration, per target, combinational from registered state.**
- Candidates are sources that are pending, enabled for the target, and have priority > threshold (strict). Priority 0 never wins.
- The winner is the highest priority; ties go to the lowest ID.
- `irq[t]` is registered and equals (winner ≠ 0).

**Collisions.**
- `cfg_we` and `cfg_re` in the same cycle: the write is performed, the read has no side effect, `cfg_rvalid`=1 and `cfg_rdata`=0.
- A register write in the same cycle as a claim: the claim uses the pre-write values.
- A complete of ID X in the same cycle as `src[X-1]` high: the gateway goes to IDLE, then re-pends on the following edge.

## Timing
- Reset values: all priorities, enables, thresholds and pending bits are 0; all gateways are IDLE; `irq`, `cfg_rdata` and `cfg_rvalid` are 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). Any claim in flight is lost.
- `src[i-1]` sampled high at edge N: pending is set after edge N, and `irq` rises after edge N+1. Source-to-irq latency is 2 cycles.
- Claim: `cfg_re` sampled at edge N. `cfg_rdata`/`cfg_rvalid` are valid after edge N. Pending clears at edge N. `irq` updates after edge N+1.
- Writes take effect at the sampling edge. `irq` reflects the new configuration one edge later.
- Maximum throughput is one access per cycle; there are no wait states.

## Test plan
- **Single source:** priority[3]=2, enable[0]=0x04, threshold[0]=0, raise `src[2]` → `irq[0]`=1 two cycles later. Claim at 0x300 returns 3 and `irq[0]` falls. `src` stays high; complete with 3 → re-pend, `irq[0]`=1 again two cycles after the complete.
- **Priority and tie:** priority[1]=priority[2]=5, priority[4]=6, all three asserted → successive claims return 4, then 1, then 2.
- **Threshold:** priority[5]=3, threshold[1]=3 → `irq[1]` stays 0. Set threshold[1]=2 → `irq[1]`=1.
- **Multi-target:** source 6 enabled on targets 0 and 1 → both `irq` rise. A claim on target 1 returns 6; a subsequent claim on target 0 returns 0 and both `irq` drop.
- **Bad complete:** write 7 to 0x300 while source 7 is IDLE → no state change. Write `cfg_we`+`cfg_re` together → `cfg_rdata`=0.
- **Reset mid-claim:** assert `h_rst` while source 2 is CLAIMED → all outputs are 0 and the pending read at 0x400 returns 0.
